// File: rtl/debouncer_pkg.sv
// Shared types and defaults for the debouncer and its helpers.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } db_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int LONG_CYCLES_DEF     = 16;

endpackage

// File: rtl/debouncer_if.sv
// Level/pulse bundle between the synchroniser side and the debouncer.
interface debouncer_if;

    logic in_sync;
    logic level;
    logic rise;
    logic fall;
    logic long_press;

    // master: whoever supplies in_sync and consumes the clean outputs
    modport master (output in_sync, input level, rise, fall, long_press);
    modport slave  (input in_sync, output level, rise, fall, long_press);

endinterface

// File: rtl/debouncer_edge_pulse.sv
// Registers a level from its next-state value and emits one-cycle rise/fall
// pulses aligned with the first cycle of the new level.
module edge_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic level_d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic level_q;
    logic rise_q;
    logic fall_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_d_i;
            rise_q  <= level_d_i & ~level_q;
            fall_q  <= ~level_d_i & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/debouncer.sv
// Consecutive-sample debouncer with rise/fall pulses.
// Optional long-press flag enabled by defining LONG_PRESS_EN.
module debouncer
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    debouncer_if.slave   bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1) begin : g_param_check
        $error("debouncer: DEBOUNCE_CYCLES must be >= 2 and LONG_CYCLES >= 1");
    end

    db_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_done;
    logic             level_d;
    logic             level;
    logic             rise;
    logic             fall;

    assign cnt_done = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                STABLE_LOW: begin
                    if (bus.in_sync) begin
                        state_q <= WAIT_HIGH;
                        cnt_q   <= CNT_W'(1);
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!bus.in_sync) begin
                        state_q <= STABLE_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_done) begin
                        state_q <= STABLE_HIGH;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                STABLE_HIGH: begin
                    if (!bus.in_sync) begin
                        state_q <= WAIT_LOW;
                        cnt_q   <= CNT_W'(1);
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                default: begin // WAIT_LOW
                    if (bus.in_sync) begin
                        state_q <= STABLE_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_done) begin
                        state_q <= STABLE_LOW;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Next debounced level; only a completed WAIT run flips it.
    // NOTE: level_d gets a default before any condition so no latch is inferred.
    always_comb begin
        level_d = (state_q == STABLE_HIGH) || (state_q == WAIT_LOW);
        if (state_q == WAIT_HIGH && bus.in_sync && cnt_done)
            level_d = 1'b1;
        else if (state_q == WAIT_LOW && !bus.in_sync && cnt_done)
            level_d = 1'b0;
    end

    edge_pulse u_edge_pulse (
        .clk       (clk),
        .rst_n     (rst_n),
        .level_d_i (level_d),
        .level_o   (level),
        .rise_o    (rise),
        .fall_o    (fall)
    );

    assign bus.level = level;
    assign bus.rise  = rise;
    assign bus.fall  = fall;

`ifdef LONG_PRESS_EN
    localparam int LONG_W = $clog2(LONG_CYCLES + 1);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);

    logic [LONG_W-1:0] long_cnt_q;
    logic [LONG_W-1:0] long_cnt_d;
    logic              long_press_q;

    // Counts cycles spent at level=1; clearing on level_d lines the drop up with fall.
    always_comb begin
        long_cnt_d = long_cnt_q;
        if (!level_d)
            long_cnt_d = '0;
        else if (level && long_cnt_q != LONG_MAX)
            long_cnt_d = long_cnt_q + LONG_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_cnt_q   <= '0;
            long_press_q <= 1'b0;
        end else begin
            long_cnt_q   <= long_cnt_d;
            long_press_q <= level_d && (long_cnt_d == LONG_MAX);
        end
    end

    assign bus.long_press = long_press_q;
`else
    assign bus.long_press = 1'b0;
`endif

endmodule

// File: tb/tb_debouncer.sv
// Directed self-checking bench for debouncer (DEBOUNCE_CYCLES=4, LONG_CYCLES=16).
module tb_debouncer;
    import debounce_pkg::*;

`ifdef LONG_PRESS_EN
    localparam logic LP_ON = 1'b1;
`else
    localparam logic LP_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    debouncer_if bus ();

    debouncer #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic el, input logic er,
                             input logic ef, input logic elp);
        check({tag, ".level"}, bus.level, el);
        check({tag, ".rise"},  bus.rise,  er);
        check({tag, ".fall"},  bus.fall,  ef);
        check({tag, ".long"},  bus.long_press, elp);
    endtask

    // Apply v for one rising edge, then check outputs on the falling edge.
    task automatic drive(input string tag, input logic v, input logic el,
                         input logic er, input logic ef, input logic elp);
        bus.in_sync = v;
        @(posedge clk);
        @(negedge clk);
        check_all(tag, el, er, ef, elp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.in_sync = 1'b0;

        // Reset held with input toggling: outputs must stay cleared.
        for (int i = 0; i < 6; i++) begin
            bus.in_sync = i[0];
            @(posedge clk);
            @(negedge clk);
            check_all($sformatf("rst_hold%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        bus.in_sync = 1'b0;
        rst_n = 1'b1;
        drive("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Clean press: level after 4th high sample, rise for one cycle.
        drive("press1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("press2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("press3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("press4", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Hold high: long_press (if built in) comes 16 cycles after rise.
        for (int i = 1; i <= 15; i++)
            drive($sformatf("hold%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive("hold16", 1'b1, 1'b1, 1'b0, 1'b0, LP_ON);
        drive("hold17", 1'b1, 1'b1, 1'b0, 1'b0, LP_ON);

        // One-cycle and three-cycle low glitches while high: no change.
        drive("g1_lo",  1'b0, 1'b1, 1'b0, 1'b0, LP_ON);
        drive("g1_hi",  1'b1, 1'b1, 1'b0, 1'b0, LP_ON);
        drive("g3_lo1", 1'b0, 1'b1, 1'b0, 1'b0, LP_ON);
        drive("g3_lo2", 1'b0, 1'b1, 1'b0, 1'b0, LP_ON);
        drive("g3_lo3", 1'b0, 1'b1, 1'b0, 1'b0, LP_ON);
        drive("g3_hi",  1'b1, 1'b1, 1'b0, 1'b0, LP_ON);

        // Release: fall on 4th low sample, long_press clears with it.
        drive("rel1", 1'b0, 1'b1, 1'b0, 1'b0, LP_ON);
        drive("rel2", 1'b0, 1'b1, 1'b0, 1'b0, LP_ON);
        drive("rel3", 1'b0, 1'b1, 1'b0, 1'b0, LP_ON);
        drive("rel4", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive("rel5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Bounce reject: 3 high, 1 low, 3 high, low.
        for (int i = 0; i < 3; i++)
            drive($sformatf("bnc_a%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("bnc_lo", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            drive($sformatf("bnc_b%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("bnc_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Restart: 2 high, 1 low, then held high needs a fresh run of 4.
        drive("rs_a0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("rs_a1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("rs_lo", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("rs_h1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("rs_h2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("rs_h3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("rs_h4", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive("rs_h5", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle clears outputs with no clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-bounce discards the partial count.
        drive("mb_h1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("mb_h2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        drive("mb_r1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("mb_r2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("mb_r3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("mb_r4", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debouncer.md
Name: debouncer

Overview:
- Sits directly downstream of `synchroniser` and consumes its `in_sync` output, which carries a button or switch level that is already in the clock domain.
- Filters contact bounce with a consecutive-sample counter and presents a clean level.
- Emits single-cycle rise and fall pulses to control logic.
- Optionally flags a long press.

Parameters:
- DEBOUNCE_CYCLES, 4, number of consecutive equal samples of `in_sync` needed to accept a new level (min 2).
- LONG_CYCLES, 16, number of cycles the accepted level must stay high before `long_press` asserts (only used with LONG_PRESS_EN; min 1).

Ports:
- clk  input  1  system clock; everything is sampled on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_sync  input  1  synchronised raw level from `synchroniser`.
- level  output  1  debounced level.
- rise  output  1  one-cycle pulse when `level` goes 0->1.
- fall  output  1  one-cycle pulse when `level` goes 1->0.
- long_press  output  1  long-press flag (tied 0 without LONG_PRESS_EN).

Behaviour:
- Reset: rst_n=0 immediately forces state=STABLE_LOW, cnt=0, level=0, rise=0, fall=0, long_press=0, long_cnt=0, with no clock needed. Deassertion takes effect at the next rising edge.
- Reset mid-bounce discards the partial count, and no pulse is emitted.
- FSM states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
- STABLE_LOW:
  - in_sync=1 -> WAIT_HIGH, cnt=1.
  - in_sync=0 -> stay, cnt=0.
- WAIT_HIGH:
  - in_sync=0 -> STABLE_LOW, cnt=0 (bounce rejected).
  - in_sync=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HIGH, level<=1, rise<=1, cnt=0.
  - Otherwise cnt+1.
- STABLE_HIGH and WAIT_LOW mirror the two states above with polarity inverted; a WAIT_LOW completion sets level<=0 and fall<=1.
- Latency: if in_sync is first sampled at a new value on edge k and holds, level changes on edge k+DEBOUNCE_CYCLES-1.
- Pulse timing: rise/fall are high for exactly the cycle following that edge, coincident with the first cycle of the new level.
- Any single sample of the old value during WAIT_x restarts the filter; accepting the new level requires a complete fresh run of DEBOUNCE_CYCLES.
- Glitches shorter than DEBOUNCE_CYCLES cycles never alter level and never pulse.
- rise and fall are never high in the same cycle.
- Counter width is $clog2(DEBOUNCE_CYCLES+1) and it cannot wrap: it is cleared before reaching DEBOUNCE_CYCLES.
- All outputs are registered; there is no combinational path from in_sync to any output.

Optional Feature:
- Macro: LONG_PRESS_EN.
- Defined:
  - long_cnt increments each cycle while level=1 and saturates at LONG_CYCLES.
  - long_press is registered and asserts on the edge where long_cnt reaches LONG_CYCLES.
  - long_press stays high until level falls; it clears in the same cycle fall pulses.
  - long_cnt clears when level=0.
- Undefined: no long_cnt logic exists, and long_press is a constant 0.

Decomposition:
- Shared package `debounce_pkg` holds:
  - the FSM state typedef (2-bit enum: STABLE_LOW=0, WAIT_HIGH=1, STABLE_HIGH=2, WAIT_LOW=3);
  - default constants DEBOUNCE_CYCLES_DEF and LONG_CYCLES_DEF.
- One sub-module is natural: `edge_pulse`, a registered level-to-rise/fall pulse generator. The top instantiates it on level.
- The FSM and counter stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with in_sync=1 toggling -> level=rise=fall=long_press=0 throughout. Drop rst_n mid-clock -> outputs clear without a clock edge.
- Clean press: DEBOUNCE_CYCLES=4, in_sync 0->1 first sampled at edge 10 and held -> level=1 after edge 13, rise=1 for exactly that cycle, and fall stays 0.
- Bounce reject: in_sync high for 3 cycles, low for 1, high for 3, low again -> level stays 0, with no rise or fall.
- Restart after bounce: high 2 cycles, low 1, then held high -> level rises 4 cycles after the final 0->1 sample, not earlier.
- Release: from level=1, in_sync=0 held -> level=0 after 4 samples, fall one cycle, rise stays 0. A 1-cycle 0 glitch during high -> no change.
- LONG_PRESS_EN with LONG_CYCLES=16: hold high -> long_press asserts 16 cycles after rise; release -> long_press clears in the fall cycle. Without the macro -> long_press is always 0.
